// File: rtl/lambda_raster_walker_pkg.sv
// Shared definitions for the lambda-generation front end.
//   DEF_*WIDTH  : default coordinate/ID widths used by all lambdagen stages
//   walk_state_e: raster walker state encoding (IDLE, WALK)
//   tri_desc_t  : triangle descriptor {tID, xmin, xmax, ymin, ymax}
package lambda_raster_walker_pkg;
  localparam int DEF_XWIDTH  = 9;
  localparam int DEF_YWIDTH  = 8;
  localparam int DEF_IDWIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } walk_state_e;

  typedef struct packed {
    logic [DEF_IDWIDTH-1:0] tid;
    logic [DEF_XWIDTH-1:0]  xmin;
    logic [DEF_XWIDTH-1:0]  xmax;
    logic [DEF_YWIDTH-1:0]  ymin;
    logic [DEF_YWIDTH-1:0]  ymax;
  } tri_desc_t;
endpackage

// File: rtl/lambda_raster_walker_if.sv
// Descriptor-in / pixel-out bundle of the raster walker.
//   slave  : walker side (consumes descriptors + stall, produces pixels)
//   master : source/sink side (drives descriptors + stall, observes pixels)
interface lambda_raster_walker_if
  import lambda_raster_walker_pkg::*;
#(
  parameter int XWIDTH  = DEF_XWIDTH,
  parameter int YWIDTH  = DEF_YWIDTH,
  parameter int IDWIDTH = DEF_IDWIDTH
);
  logic               tri_valid;
  logic               tri_ready;
  logic [IDWIDTH-1:0] tID_in;
  logic [XWIDTH-1:0]  xmin;
  logic [XWIDTH-1:0]  xmax;
  logic [YWIDTH-1:0]  ymin;
  logic [YWIDTH-1:0]  ymax;
  logic               stall;
  logic [XWIDTH-1:0]  px;
  logic [YWIDTH-1:0]  py;
  logic [IDWIDTH-1:0] tID_out;
  logic               ovalid;
  logic               olast;
  logic               drop;

  modport slave (
    input  tri_valid, tID_in, xmin, xmax, ymin, ymax, stall,
    output tri_ready, px, py, tID_out, ovalid, olast, drop
  );

  modport master (
    output tri_valid, tID_in, xmin, xmax, ymin, ymax, stall,
    input  tri_ready, px, py, tID_out, ovalid, olast, drop
  );
endinterface

// File: rtl/lambda_raster_walker.sv
// Per-triangle pixel sequencer. Accepts a triangle (tID + inclusive bbox)
// and walks the box row-major, one pixel per unstalled cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport -- tri_valid/tri_ready descriptor handshake,
//              stall in; px/py/tID_out/ovalid/olast/drop out (all registered)
module lambda_raster_walker
  import lambda_raster_walker_pkg::*;
#(
  parameter int XWIDTH  = DEF_XWIDTH,
  parameter int YWIDTH  = DEF_YWIDTH,
  parameter int IDWIDTH = DEF_IDWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  lambda_raster_walker_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_WALK = 1'(WALK);

  logic [0:0]         state;
  logic [IDWIDTH-1:0] tid_q;
  logic [XWIDTH-1:0]  xmin_q, xmax_q, cx;
  logic [YWIDTH-1:0]  ymax_q, cy;

  logic [XWIDTH-1:0]  px_q;
  logic [YWIDTH-1:0]  py_q;
  logic [IDWIDTH-1:0] tid_out_q;
  logic               ovalid_q, olast_q, drop_q;

  logic at_xend, at_last, degen;

  assign at_xend = (cx == xmax_q);
  assign at_last = at_xend && (cy == ymax_q);
  assign degen   = (bus.xmin > bus.xmax) || (bus.ymin > bus.ymax);

  // Ready depends only on the state register.
  assign bus.tri_ready = (state == ST_IDLE);
  assign bus.px        = px_q;
  assign bus.py        = py_q;
  assign bus.tID_out   = tid_out_q;
  assign bus.ovalid    = ovalid_q;
  assign bus.olast     = olast_q;
  assign bus.drop      = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tid_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymax_q    <= '0;
      cx        <= '0;
      cy        <= '0;
      px_q      <= '0;
      py_q      <= '0;
      tid_out_q <= '0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      ovalid_q <= 1'b0;
      drop_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          olast_q <= 1'b0;
          if (bus.tri_valid) begin
            if (degen) begin
              drop_q <= 1'b1;
            end else begin
              tid_q  <= bus.tID_in;
              xmin_q <= bus.xmin;
              xmax_q <= bus.xmax;
              ymax_q <= bus.ymax;
              cx     <= bus.xmin;
              cy     <= bus.ymin;
              state  <= ST_WALK;
            end
          end
        end
        ST_WALK: begin
          // Stall holds the emitted coordinates/olast and the counters.
          if (!bus.stall) begin
            ovalid_q  <= 1'b1;
            px_q      <= cx;
            py_q      <= cy;
            tid_out_q <= tid_q;
            olast_q   <= at_last;
            // Counters stay put on the final pixel so nothing steps past
            // xmax/ymax (matters when the box touches the coordinate limit).
            if (at_last) begin
              state <= ST_IDLE;
            end else if (at_xend) begin
              cx <= xmin_q;
              cy <= cy + YWIDTH'(1);
            end else begin
              cx <= cx + XWIDTH'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
